// File: rtl/siphash_nonce_sweeper.sv
// Nonce sweeper around an external pipelined SipHash core: issues nonces and tracks them with result tags.
// It keeps the first hash below threshold. SIPHASH_SWEEP_MATCH_CNT_EN adds match_count and sweeps the full range.
module siphash_nonce_sweeper #(
    parameter int LATENCY = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] key_in,
    input  logic [63:0]  nonce_base,
    input  logic [31:0]  nonce_count,
    input  logic [63:0]  threshold,
    output logic         hash_we,
    output logic [255:0] hash_key,
    output logic [63:0]  hash_nonce,
    input  logic [63:0]  hash_result,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [63:0]  found_nonce,
    output logic [63:0]  found_hash,
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
    output logic [31:0]  match_count,
`endif
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t               state;
    logic [LATENCY-1:0]   tag_v;
    logic [63:0]          tag_n [LATENCY];
    logic [63:0]          nonce;
    logic [31:0]          remaining;
    logic [63:0]          thr_q;

    logic qualified;
    logic hit;
    logic first_hit;
    logic stop_early;
    logic tags_pending;

    assign fsm_state = state;

    // tag_v[0] / tag_n[0] is the oldest entry: it lines up with hash_result this cycle.
    assign qualified    = tag_v[0];
    assign hit          = qualified && (hash_result < thr_q);
    assign first_hit    = hit && !found;
    assign tags_pending = |(tag_v >> 1);

`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
    assign stop_early = 1'b0;
`else
    assign stop_early = first_hit;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            tag_v       <= '0;
            for (int i = 0; i < LATENCY; i++) tag_n[i] <= '0;
            nonce       <= '0;
            remaining   <= '0;
            thr_q       <= '0;
            hash_we     <= 1'b0;
            hash_key    <= '0;
            hash_nonce  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
            match_count <= '0;
`endif
        end else begin
            tag_v <= (tag_v >> 1) | (LATENCY'(hash_we) << (LATENCY - 1));
            for (int i = 0; i < LATENCY - 1; i++) tag_n[i] <= tag_n[i+1];
            tag_n[LATENCY-1] <= hash_nonce;

            if (first_hit) begin
                found       <= 1'b1;
                found_nonce <= tag_n[0];
                found_hash  <= hash_result;
            end
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
            if (hit && match_count != '1) match_count <= match_count + 32'd1;
`endif

            // The first nonce is issued on the accepting edge, so hash_we rises one cycle after start.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        hash_key    <= key_in;
                        thr_q       <= threshold;
                        found       <= 1'b0;
                        found_nonce <= '0;
                        found_hash  <= '0;
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
                        match_count <= '0;
`endif
                        if (nonce_count == 32'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= SWEEP;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            hash_we    <= 1'b1;
                            hash_nonce <= nonce_base;
                            nonce      <= nonce_base + 64'd1;
                            remaining  <= nonce_count - 32'd1;
                        end
                    end
                end
                SWEEP: begin
                    if (stop_early || remaining == 32'd0) begin
                        hash_we <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        hash_we    <= 1'b1;
                        hash_nonce <= nonce;
                        nonce      <= nonce + 64'd1;
                        remaining  <= remaining - 32'd1;
                    end
                end
                DRAIN: begin
                    if (!tags_pending) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_siphash_nonce_sweeper.sv
// Scoreboard bench for siphash_nonce_sweeper with a model hasher of fixed latency.
// Define SIPHASH_SWEEP_MATCH_CNT_EN to also exercise match_count.
module tb_siphash_nonce_sweeper;

    localparam int LAT = 11;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [255:0] key_in;
    logic [63:0]  nonce_base;
    logic [31:0]  nonce_count;
    logic [63:0]  threshold;
    logic         hash_we;
    logic [255:0] hash_key;
    logic [63:0]  hash_nonce;
    logic [63:0]  hash_result;
    logic         busy;
    logic         done;
    logic         found;
    logic [63:0]  found_nonce;
    logic [63:0]  found_hash;
    logic [1:0]   fsm_state;
    logic [31:0]  mcount;
`ifndef SIPHASH_SWEEP_MATCH_CNT_EN
    assign mcount = 32'd0;
`endif

    siphash_nonce_sweeper #(.LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in),
        .nonce_base(nonce_base), .nonce_count(nonce_count), .threshold(threshold),
        .hash_we(hash_we), .hash_key(hash_key), .hash_nonce(hash_nonce),
        .hash_result(hash_result), .busy(busy), .done(done), .found(found),
        .found_nonce(found_nonce), .found_hash(found_hash),
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
        .match_count(mcount),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        found;
        logic [63:0] nonce;
        logic [63:0] hash;
        logic [31:0] mcount;
    } res_t;

    logic [63:0] exp_q[$];
    res_t        res_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          mode = 0;
    logic [255:0] cur_key = '0;
    logic        done_d = 1'b0;

    // Model hasher: mode 0 all-ones, 1 hits nonce 3, 2 hits nonces 2/5/7, 3 always zero.
    function automatic logic [63:0] model_hash(input logic [63:0] n);
        case (mode)
            1: return (n == 64'd3) ? 64'h10 : 64'hFFFF_FFFF_FFFF_FF00;
            2: return (n == 64'd2 || n == 64'd5 || n == 64'd7) ? 64'h5 : 64'hFFFF_FFFF_FFFF_FF00;
            3: return 64'h0;
            default: return '1;
        endcase
    endfunction

    // Unqualified slots carry zero so a wrongly qualified slot would look like a match.
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= hash_we ? model_hash(hash_nonce) : 64'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign hash_result = pipe[LAT-1];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        res_t        r;
        if (hash_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {192'd0, hash_nonce}, 256'd0 - 256'd1);
            end else begin
                e = exp_q.pop_front();
                chk("issue_nonce", {192'd0, hash_nonce}, {192'd0, e});
                chk("issue_key", hash_key, cur_key);
            end
        end
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (res_q.size() == 0) begin
                chk("unexpected_done", 256'd1, 256'd0);
            end else begin
                r = res_q.pop_front();
                chk("found", {255'd0, found}, {255'd0, r.found});
                chk("found_nonce", {192'd0, found_nonce}, {192'd0, r.nonce});
                chk("found_hash", {192'd0, found_hash}, {192'd0, r.hash});
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
                chk("match_count", {224'd0, mcount}, {224'd0, r.mcount});
`endif
            end
        end
        done_d = done;
    end

    task automatic push_range(input logic [63:0] base, input int n);
        logic [63:0] v = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = v + 64'd1;
        end
    endtask

    task automatic run_sweep(input logic [63:0] base, input logic [31:0] cnt, input logic [63:0] thr,
                             input logic [255:0] key, input bit poke, input int exp_cycles,
                             input string name);
        int cycles;
        cur_key = key;
        nonce_base = base; nonce_count = cnt; threshold = thr; key_in = key; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nonce_base = 64'h999; nonce_count = 32'd1; threshold = '1; key_in = ~key;
        cycles = 1;
        while (done !== 1'b1 && cycles < 300) begin
            start = poke && (cycles == 3);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk({name, "_done_latency"}, 256'(cycles), 256'(exp_cycles));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_hash_we"}, {255'd0, hash_we}, 256'd0);
        chk({name, "_hash_key"}, hash_key, 256'd0);
        chk({name, "_hash_nonce"}, {192'd0, hash_nonce}, 256'd0);
        chk({name, "_flags"}, {252'd0, busy, done, found, 1'b0}, 256'd0);
        chk({name, "_found_nonce"}, {192'd0, found_nonce}, 256'd0);
        chk({name, "_found_hash"}, {192'd0, found_hash}, 256'd0);
        chk({name, "_state"}, {254'd0, fsm_state}, 256'd0);
        chk({name, "_match_count"}, {224'd0, mcount}, 256'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; key_in = '0;
        nonce_base = '0; nonce_count = '0; threshold = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-length sweep: DONE one cycle after start, no issues.
        mode = 3;
        res_q.push_back('{1'b0, 64'd0, 64'd0, 32'd0});
        run_sweep(64'd0, 32'd0, 64'h11, {4{64'hA5A5_0000_1111_2222}}, 1'b0, 1, "count0");

        // Threshold zero never matches, even with a zero hash.
        push_range(64'd0, 5);
        res_q.push_back('{1'b0, 64'd0, 64'd0, 32'd0});
        run_sweep(64'd0, 32'd5, 64'd0, {4{64'h0123_4567_89AB_CDEF}}, 1'b0, 17, "thr0");
        repeat (3) @(negedge clk);
        chk("done_hold", {255'd0, done}, 256'd1);

        // Single match at nonce 3.
        mode = 1;
`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
        push_range(64'd0, 20);
        res_q.push_back('{1'b1, 64'd3, 64'h10, 32'd1});
        run_sweep(64'd0, 32'd20, 64'h11, {4{64'hDEAD_BEEF_0000_0001}}, 1'b0, 32, "match3");
`else
        push_range(64'd0, 15);
        res_q.push_back('{1'b1, 64'd3, 64'h10, 32'd0});
        run_sweep(64'd0, 32'd20, 64'h11, {4{64'hDEAD_BEEF_0000_0001}}, 1'b0, 27, "match3");
`endif

        // Nonce wrap, with a start pulse while busy that must be ignored.
        mode = 0;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        res_q.push_back('{1'b0, 64'd0, 64'd0, 32'd0});
        run_sweep(64'hFFFF_FFFF_FFFF_FFFE, 32'd4, 64'h11, {4{64'h5555_AAAA_5555_AAAA}}, 1'b1, 16, "wrap");

        // Reset in the middle of a sweep, then restart at 0x100.
        cur_key = {4{64'h1357_9BDF_2468_ACE0}};
        key_in = cur_key; nonce_base = 64'h50; nonce_count = 32'd20; threshold = 64'h11;
        start = 1'b1;
        push_range(64'h50, 5);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        reset_n = 1'b1;
        push_range(64'h100, 3);
        res_q.push_back('{1'b0, 64'd0, 64'd0, 32'd0});
        run_sweep(64'h100, 32'd3, '1, {4{64'h0F0F_F0F0_0F0F_F0F0}}, 1'b0, 15, "restart");

`ifdef SIPHASH_SWEEP_MATCH_CNT_EN
        // Several matches: first one kept, all counted, full range swept.
        mode = 2;
        push_range(64'd0, 10);
        res_q.push_back('{1'b1, 64'd2, 64'h5, 32'd3});
        run_sweep(64'd0, 32'd10, 64'h11, {4{64'hCAFE_F00D_CAFE_F00D}}, 1'b0, 22, "multi");
`endif

        repeat (5) @(negedge clk);
        chk("issues_left", 256'(exp_q.size()), 256'd0);
        chk("results_left", 256'(res_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
